// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// Module   : fp32_pkg
// Purpose  : Shared FP32 constants and divider state encoding.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fp32_pkg;
  localparam int          FP32_BIAS = 127;
  localparam logic [7:0]  EXP_INF   = 8'hFF;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam int          QBITS     = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

`default_nettype wire

// File: rtl/div_normalize.sv
// ---------------------------------------------------------------------------
// Module   : div_normalize
// Purpose  : Combinational normalization and special-case packing of a quotient.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module div_normalize
  import fp32_pkg::*;
(
  input  logic [9:0]  exp_in,
  input  logic [24:0] q,
  input  logic        sign,
  input  logic        a_zero,
  input  logic        b_zero,
  input  logic        nan_in,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  logic [22:0] frac;
  logic [9:0]  exp_n;

  always_comb begin
    frac        = q[24] ? q[23:1] : q[22:0];
    exp_n       = q[24] ? exp_in : exp_in - 10'd1;
    result      = 32'h0;
    overflow    = 1'b0;
    underflow   = 1'b0;
    div_by_zero = 1'b0;
    // Priority order matters: a zero divisor dominates even a NaN/inf dividend.
    if (b_zero) begin
      div_by_zero = 1'b1;
      result      = {sign, EXP_INF, 23'h0};
    end else if (a_zero) begin
      result = {sign, 31'h0};
    end else if (nan_in) begin
      result = FP32_QNAN;
    end else if ($signed(exp_n) > 10'sd254) begin
      overflow = 1'b1;
      result   = {sign, EXP_INF, 23'h0};
    end else if ($signed(exp_n) < 10'sd1) begin
      underflow = 1'b1;
      result    = {sign, 31'h0};
    end else begin
      result = {sign, exp_n[7:0], frac};
    end
  end

endmodule

`default_nettype wire

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// Module   : divider
// Purpose  : Sequential FP32 divider, restoring mantissa division, 27-clock latency.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DIV  = DIV;
  localparam logic [1:0] ST_NORM = NORM;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [25:0] rem;
  logic [23:0] dvs;
  logic [24:0] q;
  logic [9:0]  exp_r;
  logic        sign;
  logic        a_zero;
  logic        b_zero;
  logic        nan_op;

  logic [25:0] trial;
  logic        q_bit;
  logic [31:0] n_result;
  logic        n_overflow;
  logic        n_underflow;
  logic        n_div_by_zero;

  // rem stays below 2*dvs after every step, so 26 bits hold rem<<1 without loss.
  assign trial = rem - {2'b00, dvs};
  assign q_bit = (rem >= {2'b00, dvs});
  assign busy  = (state != ST_IDLE);

  div_normalize u_norm (
    .exp_in      (exp_r),
    .q           (q),
    .sign        (sign),
    .a_zero      (a_zero),
    .b_zero      (b_zero),
    .nan_in      (nan_op),
    .result      (n_result),
    .overflow    (n_overflow),
    .underflow   (n_underflow),
    .div_by_zero (n_div_by_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= 5'd0;
      rem         <= 26'd0;
      dvs         <= 24'd0;
      q           <= 25'd0;
      exp_r       <= 10'd0;
      sign        <= 1'b0;
      a_zero      <= 1'b0;
      b_zero      <= 1'b0;
      nan_op      <= 1'b0;
      done        <= 1'b0;
      result      <= 32'h0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sign        <= A[31] ^ B[31];
            exp_r       <= {2'b00, A[30:23]} - {2'b00, B[30:23]} + 10'(FP32_BIAS);
            rem         <= {2'b01, A[22:0]};
            dvs         <= {1'b1, B[22:0]};
            q           <= 25'd0;
            count       <= 5'd0;
            a_zero      <= (A[30:23] == 8'h00);
            b_zero      <= (B[30:23] == 8'h00);
            nan_op      <= (A[30:23] == EXP_INF) || (B[30:23] == EXP_INF);
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            state       <= ST_DIV;
          end
        end
        ST_DIV: begin
          q     <= {q[23:0], q_bit};
          rem   <= q_bit ? {trial[24:0], 1'b0} : {rem[24:0], 1'b0};
          count <= count + 5'd1;
          if (count == 5'(QBITS - 1)) state <= ST_NORM;
        end
        ST_NORM: begin
          result      <= n_result;
          overflow    <= n_overflow;
          underflow   <= n_underflow;
          div_by_zero <= n_div_by_zero;
          done        <= 1'b1;
          state       <= ST_DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// Module   : tb_divider
// Purpose  : Self-checking scoreboard bench for the sequential FP32 divider.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // One complete operation; inject=1 pulses start with other operands mid-DIV.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eres,
                        input logic eovf, input logic eunf, input logic edbz, input bit inject);
    exp_t e;
    int   lat;
    e.res = eres; e.ovf = eovf; e.unf = eunf; e.dbz = edbz;
    sb.push_back(e);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check("busy_rise", 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      if (inject && lat == 9) begin
        A = 32'h3F800000; B = 32'h3F800000; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), 32'd27);
    check("busy_at_done", 32'(busy), 32'd1);
    e = sb.pop_front();
    check("result", result, e.res);
    check("overflow", 32'(overflow), 32'(e.ovf));
    check("underflow", 32'(underflow), 32'(e.unf));
    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    // start during the DONE cycle must be dropped
    A = 32'h3F800000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_fall", 32'(busy), 32'd0);
    check("done_fall", 32'(done), 32'd0);
    check("result_hold", result, e.res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = 32'h0; B = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {29'd0, overflow, underflow, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h00000000, 32'hBF800000, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort in mid-operation with asynchronous reset
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 1'b0, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
